// File: rtl/blocpu_pkg.sv
// rtl/blocpu_pkg.sv - shared state encoding and error codes for the blocpu program loader
package blocpu_pkg;

    typedef enum logic [3:0] {
        LEN_HI,
        LEN_LO,
        INS_HI,
        INS_LO,
        SETUP,
        STROBE,
        CKSUM,
        CORE_RESET,
        START,
        RUN,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_NIBBLE = 2'b01;
    localparam logic [1:0] ERR_CKSUM  = 2'b10;

    function automatic logic state_accepts_byte(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == INS_HI) ||
               (s == INS_LO) || (s == CKSUM);
    endfunction

endpackage

// File: rtl/blocpu_sat_counter.sv
// rtl/blocpu_sat_counter.sv - width-parameterised saturating up-counter with clear and enable
module blocpu_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             in_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/blocpu_program_loader.sv
// rtl/blocpu_program_loader.sv - length-prefixed program loader and run sequencer for the blocpu core
// Optional trailing XOR checksum byte enabled by BLOCPU_LOADER_CHECKSUM_EN.
module blocpu_program_loader
    import blocpu_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 12,
    parameter int ADDRESS_WIDTH     = 16,
    parameter int RESET_CYCLES      = 2,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                         clock,
    input  logic                         in_reset,
    input  logic [7:0]                   in_byte,
    input  logic                         in_byte_valid,
    output logic                         out_byte_ready,
    input  logic                         in_clear,
    input  logic                         in_core_running,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [ADDRESS_WIDTH-1:0]     out_instruction_address,
    output logic                         out_instruction_write,
    output logic                         out_core_reset,
    output logic                         out_core_running,
    output logic                         out_busy,
    output logic                         out_done,
    output logic                         out_error,
    output logic [1:0]                   out_error_code,
    output logic [COUNT_WIDTH-1:0]       out_run_cycles
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

`ifdef BLOCPU_LOADER_CHECKSUM_EN
    localparam state_t LOAD_END_STATE = CKSUM;
`else
    localparam state_t LOAD_END_STATE = CORE_RESET;
`endif

    state_t                         r_state;
    state_t                         w_next;
    logic [ADDRESS_WIDTH-1:0]       r_length;
    logic [ADDRESS_WIDTH-1:0]       r_address;
    logic [ADDRESS_WIDTH-1:0]       r_instr_addr;
    logic [INSTRUCTION_WIDTH-1:0]   r_instruction;
    logic [3:0]                     r_ins_hi;
    logic [RC_W-1:0]                r_reset_count;
    logic                           r_seen;
    logic [1:0]                     r_err_code;

    logic                           w_transfer;
    logic [ADDRESS_WIDTH-1:0]       w_new_length;
    logic [ADDRESS_WIDTH-1:0]       w_addr_next;
    logic                           w_last_word;
    logic                           w_bad_nibble;
    logic                           w_cnt_clear;
    logic                           w_cnt_enable;

    assign w_transfer   = in_byte_valid && out_byte_ready;
    assign w_new_length = {r_length[ADDRESS_WIDTH-1:8], in_byte};
    assign w_addr_next  = r_address + ADDRESS_WIDTH'(1);
    assign w_last_word  = (w_addr_next == r_length);
    assign w_bad_nibble = (in_byte[7:4] != 4'h0);

`ifdef BLOCPU_LOADER_CHECKSUM_EN
    logic [7:0] r_xsum;
    logic       w_cksum_ok;

    assign w_cksum_ok = ((r_xsum ^ in_byte) == 8'h00);

    // Running XOR restarts with the first length byte of every stream.
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            r_xsum <= 8'h00;
        end else if (!in_clear && w_transfer) begin
            if (r_state == LEN_HI) begin
                r_xsum <= in_byte;
            end else if (r_state != CKSUM) begin
                r_xsum <= r_xsum ^ in_byte;
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            r_state <= LEN_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (in_clear) begin
            w_next = LEN_HI;
        end else begin
            case (r_state)
                LEN_HI:     if (w_transfer) w_next = LEN_LO;
                LEN_LO:     if (w_transfer) w_next = (w_new_length != '0) ? INS_HI : LOAD_END_STATE;
                INS_HI:     if (w_transfer) w_next = w_bad_nibble ? ERROR : INS_LO;
                INS_LO:     if (w_transfer) w_next = SETUP;
                SETUP:      w_next = STROBE;
                STROBE:     w_next = w_last_word ? LOAD_END_STATE : INS_HI;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                CKSUM:      if (w_transfer) w_next = w_cksum_ok ? CORE_RESET : ERROR;
`else
                CKSUM:      w_next = LEN_HI;
`endif
                CORE_RESET: if (r_reset_count == '0) w_next = START;
                START:      w_next = RUN;
                RUN:        if (r_seen && !in_core_running) w_next = DONE;
                DONE:       w_next = DONE;
                ERROR:      w_next = ERROR;
                default:    w_next = LEN_HI;
            endcase
        end
    end

    // A clear leaves the datapath alone; the next stream reloads everything it needs.
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            r_length      <= '0;
            r_address     <= '0;
            r_instr_addr  <= '0;
            r_instruction <= '0;
            r_ins_hi      <= 4'h0;
            r_reset_count <= '0;
            r_seen        <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else if (!in_clear) begin
            case (r_state)
                LEN_HI: begin
                    if (w_transfer) r_length[ADDRESS_WIDTH-1:8] <= in_byte;
                end
                LEN_LO: begin
                    if (w_transfer) begin
                        r_length      <= w_new_length;
                        r_address     <= '0;
                        r_reset_count <= RC_LOAD;
                    end
                end
                INS_HI: begin
                    if (w_transfer) begin
                        r_ins_hi <= in_byte[3:0];
                        if (w_bad_nibble) r_err_code <= ERR_NIBBLE;
                    end
                end
                INS_LO: begin
                    if (w_transfer) begin
                        r_instruction <= {r_ins_hi, in_byte};
                        r_instr_addr  <= r_address;
                    end
                end
                STROBE: begin
                    r_address     <= w_addr_next;
                    r_reset_count <= RC_LOAD;
                end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
                CKSUM: begin
                    if (w_transfer && !w_cksum_ok) r_err_code <= ERR_CKSUM;
                end
`endif
                CORE_RESET: begin
                    if (r_reset_count != '0) r_reset_count <= r_reset_count - RC_W'(1);
                end
                START: begin
                    r_seen <= 1'b0;
                end
                RUN: begin
                    if (in_core_running) r_seen <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_cnt_clear  = !in_clear && (r_state == LEN_HI) && w_transfer;
    assign w_cnt_enable = !in_clear && (r_state == RUN);

    blocpu_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_run_counter (
        .clock    (clock),
        .in_reset (in_reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_enable),
        .o_count  (out_run_cycles)
    );

    always_comb begin
        out_byte_ready          = !in_reset && state_accepts_byte(r_state);
        out_instruction         = r_instruction;
        out_instruction_address = r_instr_addr;
        out_instruction_write   = (r_state == STROBE);
        out_core_reset          = (r_state == CORE_RESET);
        out_core_running        = (r_state == START);
        out_busy                = !((r_state == LEN_HI) || (r_state == DONE) || (r_state == ERROR));
        out_done                = (r_state == DONE);
        out_error               = (r_state == ERROR);
        out_error_code          = (r_state == ERROR) ? r_err_code : ERR_NONE;
    end

endmodule

// File: doc/blocpu_program_loader.md
Name: blocpu_program_loader

Overview:
- Byte-stream program loader and run sequencer for the blocpu core.
- Receives a length-prefixed program over a valid/ready byte interface and writes each 12-bit instruction into the core's instruction memory using a write strobe.
- Then pulses core reset and core running, and monitors the core until it halts, counting run cycles.
- Sits between the host/UART front end and the core's programming and control pins.

Parameters:
- INSTRUCTION_WIDTH, 12, instruction word width; fixed at 12 by the 2-byte instruction encoding.
- ADDRESS_WIDTH, 16, instruction address width; also the program length field width.
- RESET_CYCLES, 2, cycles out_core_reset is held high; minimum 1.
- COUNT_WIDTH, 32, width of the run cycle counter.

Ports:
- clock  in  1  system clock
- in_reset  in  1  asynchronous, active-high block reset
- in_byte  in  8  stream byte
- in_byte_valid  in  1  in_byte valid
- out_byte_ready  out  1  loader accepts a byte this cycle
- in_clear  in  1  synchronous return to IDLE from any state
- in_core_running  in  1  core's out_running
- out_instruction  out  12  instruction to core
- out_instruction_address  out  16  instruction address to core
- out_instruction_write  out  1  core write strobe; the core samples on the rising edge
- out_core_reset  out  1  core reset pulse
- out_core_running  out  1  core start pulse
- out_busy  out  1  state is not IDLE, DONE or ERROR
- out_done  out  1  core halted after a run
- out_error  out  1  load failed
- out_error_code  out  2  01 = bad instruction high nibble, 10 = checksum mismatch, 00 = none
- out_run_cycles  out  COUNT_WIDTH  cycles spent in RUN, saturating

Behaviour:
- Reset: in_reset is asynchronous and active-high; clock is clock.
  - State = LEN_HI; all outputs 0; internal length, address, checksum and seen flag cleared.
- Byte transfer occurs on a clock edge where in_byte_valid and out_byte_ready are both 1.
  - out_byte_ready = 1 only in LEN_HI, LEN_LO, INS_HI, INS_LO and CKSUM.
- LEN_HI: on transfer, length[15:8] <= byte; go to LEN_LO.
  - out_run_cycles is cleared on the first LEN_HI transfer.
- LEN_LO: on transfer, length[7:0] <= byte; address <= 0.
  - Go to INS_HI if length != 0.
  - If length == 0, go to CKSUM when the checksum feature is enabled, else CORE_RESET. This re-runs the existing memory.
- INS_HI: on transfer, if byte[7:4] != 0, go to ERROR with code 01. Otherwise hold byte[3:0] as instruction[11:8] and go to INS_LO.
- INS_LO: on transfer, instruction[7:0] <= byte; go to SETUP.
- SETUP, one cycle: out_instruction and out_instruction_address driven; out_instruction_write = 0.
- STROBE, one cycle: out_instruction_write = 1; data and address held stable.
  - Then address <= address + 1.
  - If address + 1 == length, go to CKSUM or CORE_RESET; else go to INS_HI.
  - out_instruction and out_instruction_address hold their last values after the strobe.
- CORE_RESET: out_core_reset = 1 for exactly RESET_CYCLES cycles, then START.
- START, one cycle: out_core_running = 1; seen <= 0; go to RUN.
- RUN:
  - out_run_cycles increments each cycle and saturates at all-ones.
  - seen <= 1 when in_core_running == 1.
  - When seen == 1 and in_core_running == 0, go to DONE.
  - If the core never rises, the loader stays in RUN until in_clear.
- DONE: out_done = 1; out_run_cycles frozen.
- ERROR: out_error = 1 and out_error_code held. The core is never reset or started from a failed load.
- in_clear has priority over all transitions. From any state, the next state is LEN_HI and all strobes drop to 0 the same edge.
  - Mid-strobe clear is allowed; the core may have latched that one word.
  - out_run_cycles is retained.
- A clear issued in RUN does not stop the core; the host must reload or reset.
- Length wrap: address is 16-bit, so length 0xFFFF writes addresses 0x0000 through 0xFFFE.

Optional Feature:
- Macro: BLOCPU_LOADER_CHECKSUM_EN
- Defined:
  - An 8-bit running XOR over every stream byte (length and instruction bytes) is kept.
  - A CKSUM state accepts one trailing byte.
  - If running XOR ^ byte == 0, go to CORE_RESET; else go to ERROR with code 10.
- Undefined: no CKSUM state; the loader goes directly to CORE_RESET; code 10 is never produced.

Decomposition:
- Package blocpu_pkg holds:
  - the state enum (LEN_HI, LEN_LO, INS_HI, INS_LO, SETUP, STROBE, CKSUM, CORE_RESET, START, RUN, DONE, ERROR);
  - error-code constants ERR_NONE, ERR_NIBBLE, ERR_CKSUM.
- One sub-module, blocpu_sat_counter (width-parameterised, enable/clear, saturating), used for out_run_cycles. The RESET_CYCLES countdown stays inline.

Test Plan:
- Stream 00 02 08 05 0C 41 with a core model that halts after 7 cycles:
  - writes 0x805 at 0x0000 and 0xC41 at 0x0001, each with one-cycle setup and one-cycle strobe;
  - core reset held 2 cycles, then a 1-cycle running pulse;
  - out_done = 1; out_run_cycles = 7 + latency as specified.
- Stream 00 01 18 00: out_error = 1, code 01; no strobe, out_core_reset or out_core_running ever asserted.
- Stream 00 00: no writes; core reset then start; DONE after the core halts.
- Assert in_clear during the STROBE of the second word: the next cycle is LEN_HI, write = 0, busy = 0; a subsequent full stream loads correctly.
- in_byte_valid toggled randomly: every byte accepted exactly once; out_byte_ready = 0 throughout SETUP, STROBE, CORE_RESET, RUN.
- With BLOCPU_LOADER_CHECKSUM_EN: stream 00 01 08 05 0C runs to DONE (XOR 00^01^08^05 = 0C); stream 00 01 08 05 0D gives ERROR code 10.
